active_transfer_host: RTL and testbench

Host-side counterpart of the device single-byte transfer channel. Used in simulation and in the bridge build to drive the 32-bit host-to-device bus (uc_in) and monitor the 30-bit device-to-host bus (uc_out).
- TX path: serialises queued host-to-device bytes into the addr/cmd/byte bus sequence the device receiver expects.
- RX path: captures device-to-host transfers into a small show-ahead FIFO and pulses the host-busy flag (bit 31).

---
 rtl/active_transfer_host.sv | 168 ++++++++++++++++
 tb/tb_active_transfer_host.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/active_transfer_host.sv
// active_transfer_host
// Host-side driver/monitor for the single-byte transfer channel.
//   TX: serialises one queued byte per request onto uc_in as
//       ADDR (1 cycle) -> CMD (CMD_CYCLES) -> GAP (GAP_CYCLES, all zero).
//   RX: rising edge of uc_out[17] captures {addr, byte} into a show-ahead
//       FIFO and (re)loads the host-busy counter that drives uc_in[31].
// Ports:
//   uc_clk, uc_reset          clock, async active-high reset
//   tx_valid/tx_ready         request handshake; tx_addr/tx_data payload
//   tx_busy                   TX sequence in progress
//   uc_in[31:0]               host-to-device bus
//   uc_out[29:0]              device-to-host bus
//   rx_valid/rx_addr/rx_data  FIFO head (show-ahead); rx_pop consumes it
//   rx_count                  entries held; rx_overflow sticky drop flag
//   ovf_clr                   clears rx_overflow
module active_transfer_host #(
    parameter int CMD_CYCLES  = 3,
    parameter int GAP_CYCLES  = 2,
    parameter int BUSY_CYCLES = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        uc_clk,
    input  logic        uc_reset,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [2:0]  tx_addr,
    input  logic [7:0]  tx_data,
    output logic        tx_busy,
    output logic [31:0] uc_in,
    input  logic [29:0] uc_out,
    output logic        rx_valid,
    output logic [2:0]  rx_addr,
    output logic [7:0]  rx_data,
    input  logic        rx_pop,
    output logic [6:0]  rx_count,
    output logic        rx_overflow,
    input  logic        ovf_clr
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [6:0]  DEPTH_C = 7'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        TX_IDLE = 4'b0001,
        TX_ADDR = 4'b0010,
        TX_CMD  = 4'b0100,
        TX_GAP  = 4'b1000
    } tx_state_e;

    tx_state_e         state_q, state_d;
    logic [3:0]        tcnt_q, tcnt_d;
    logic [2:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    logic              prev_q, prev_d;
    logic [3:0]        busy_q, busy_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [6:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [10:0]       mem [FIFO_DEPTH];

    logic capture, pop_ok, push_ok, full;
    logic unused_bits;

    assign unused_bits = ^{uc_out[26:18], uc_out[8:0]};

    // ---------------- TX FSM ----------------
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            TX_IDLE: if (tx_valid) begin
                addr_d  = tx_addr;
                data_d  = tx_data;
                state_d = TX_ADDR;
            end
            TX_ADDR: begin
                state_d = TX_CMD;
                tcnt_d  = 4'(CMD_CYCLES - 1);
            end
            TX_CMD: if (tcnt_q == 4'd0) begin
                state_d = TX_GAP;
                tcnt_d  = 4'(GAP_CYCLES - 1);
            end else begin
                tcnt_d  = tcnt_q - 4'd1;
            end
            TX_GAP: if (tcnt_q == 4'd0) begin
                state_d = TX_IDLE;
            end else begin
                tcnt_d  = tcnt_q - 4'd1;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_ready = (state_q == TX_IDLE);
    assign tx_busy  = (state_q != TX_IDLE);

    // Bus is a pure decode of flops, so reset clears it without waiting for a clock.
    always_comb begin
        uc_in     = 32'd0;
        uc_in[31] = (busy_q != 4'd0);
        if (state_q == TX_ADDR || state_q == TX_CMD) uc_in[29:27] = addr_q;
        if (state_q == TX_CMD) begin
            uc_in[17]   = 1'b1;
            uc_in[16:9] = data_q;
        end
    end

    // ---------------- RX capture / FIFO ----------------
    assign capture = uc_out[17] & ~prev_q;
    assign full    = (count_q == DEPTH_C);
    assign pop_ok  = rx_pop && (count_q != 7'd0);
    // Full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = capture && (!full || pop_ok);

    always_comb begin
        prev_d   = uc_out[17];
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + 7'd1;
        else if (!push_ok && pop_ok) count_d = count_q - 7'd1;
        // Dropped captures still extend busy.
        busy_d = capture ? 4'(BUSY_CYCLES)
               : (busy_q != 4'd0) ? busy_q - 4'd1 : busy_q;
        ovf_d  = ovf_q;
        if (ovf_clr)                  ovf_d = 1'b0;
        if (capture && full && !rx_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge uc_clk) begin
        if (push_ok) mem[wr_ptr_q] <= {uc_out[29:27], uc_out[16:9]};
    end

    assign rx_valid    = (count_q != 7'd0);
    assign rx_addr     = rx_valid ? mem[rd_ptr_q][10:8] : 3'd0;
    assign rx_data     = rx_valid ? mem[rd_ptr_q][7:0]  : 8'd0;
    assign rx_count    = count_q;
    assign rx_overflow = ovf_q;

    always_ff @(posedge uc_clk or posedge uc_reset) begin
        if (uc_reset) begin
            state_q  <= TX_IDLE;
            tcnt_q   <= 4'd0;
            addr_q   <= 3'd0;
            data_q   <= 8'd0;
            prev_q   <= 1'b0;
            busy_q   <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 7'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            prev_q   <= prev_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_active_transfer_host.sv
module tb_active_transfer_host;
    logic        uc_clk = 1'b0;
    logic        uc_reset;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  tx_addr;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [31:0] uc_in;
    logic [29:0] uc_out;
    logic        rx_valid;
    logic [2:0]  rx_addr;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic [6:0]  rx_count;
    logic        rx_overflow;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;

    active_transfer_host dut (
        .uc_clk(uc_clk), .uc_reset(uc_reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_addr(tx_addr),
        .tx_data(tx_data), .tx_busy(tx_busy), .uc_in(uc_in),
        .uc_out(uc_out), .rx_valid(rx_valid), .rx_addr(rx_addr),
        .rx_data(rx_data), .rx_pop(rx_pop), .rx_count(rx_count),
        .rx_overflow(rx_overflow), .ovf_clr(ovf_clr)
    );

    always #5 uc_clk = ~uc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land on the falling edge for sampling and driving.
    task automatic tick();
        @(posedge uc_clk);
        @(negedge uc_clk);
    endtask

    function automatic logic [29:0] dev_word(input logic [2:0] a, input logic [7:0] d);
        logic [29:0] w;
        w = 30'd0;
        w[29:27] = a;
        w[17]    = 1'b1;
        w[16:9]  = d;
        return w;
    endfunction

    // Device-style transfer: cmd bit held 3 cycles, then one idle cycle.
    task automatic dev_xfer(input logic [2:0] a, input logic [7:0] d);
        uc_out = dev_word(a, d);
        repeat (3) tick();
        uc_out = 30'd0;
        tick();
    endtask

    logic [7:0] exp_d [8];
    logic [2:0] exp_a [8];

    initial begin
        int n_byte;
        logic rdy_seen;
        uc_reset = 1'b1; tx_valid = 0; tx_addr = 0; tx_data = 0;
        uc_out = 0; rx_pop = 0; ovf_clr = 0;
        repeat (2) tick();
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_uc_in", uc_in, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_count", {25'd0, rx_count}, 32'd0);
        chk("rst_ovf", {31'd0, rx_overflow}, 32'd0);
        chk("rst_rx_head", {21'd0, rx_addr, rx_data}, 32'd0);
        uc_reset = 1'b0;
        tick();

        // 1: single TX, addr 3 / 0xA5
        tx_valid = 1; tx_addr = 3'd3; tx_data = 8'hA5;
        tick(); tx_valid = 0;
        chk("t1_addr_cycle", uc_in, 32'h1800_0000);
        chk("t1_busy", {31'd0, tx_busy}, 32'd1);
        chk("t1_not_ready", {31'd0, tx_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t1_cmd_cycle", uc_in, 32'h1803_4A00);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); chk("t1_gap_cycle", uc_in, 32'd0);
            chk("t1_gap_not_ready", {31'd0, tx_ready}, 32'd0);
        end
        tick();
        chk("t1_ready_c7", {31'd0, tx_ready}, 32'd1);

        // 2: back-to-back bytes with tx_valid held high
        tx_valid = 1; tx_addr = 3'd2;
        for (int k = 0; k < 3; k++) begin
            chk("t2_ready_at_accept", {31'd0, tx_ready}, 32'd1);
            tx_data = 8'(k + 1);
            tick();
            n_byte = 0; rdy_seen = 0;
            for (int c = 1; c <= 6; c++) begin
                if (uc_in[17] && uc_in[16:9] == 8'(k + 1)) n_byte++;
                if (tx_ready) rdy_seen = 1;
                if (c < 6) tick();
            end
            chk("t2_byte_cycles", n_byte, 32'd3);
            chk("t2_ready_early", {31'd0, rdy_seen}, 32'd0);
            tick();
        end
        tx_valid = 0;

        // 3: one held device transfer -> one entry, 4 busy cycles
        uc_out = dev_word(3'd5, 8'h3C);
        tick();
        chk("t3_count", {25'd0, rx_count}, 32'd1);
        chk("t3_head", {21'd0, rx_addr, rx_data}, {21'd0, 3'd5, 8'h3C});
        chk("t3_busy_c1", uc_in, 32'h8000_0000);
        tick(); chk("t3_busy_c2", {31'd0, uc_in[31]}, 32'd1);
        tick(); chk("t3_busy_c3", {31'd0, uc_in[31]}, 32'd1);
        uc_out = 30'd0;
        tick(); chk("t3_busy_c4", {31'd0, uc_in[31]}, 32'd1);
        tick(); chk("t3_busy_off", uc_in, 32'd0);
        chk("t3_single_entry", {25'd0, rx_count}, 32'd1);
        rx_pop = 1; tick(); rx_pop = 0;
        chk("t3_popped", {31'd0, rx_valid}, 32'd0);

        // 4: nine transfers without popping
        for (int i = 0; i < 9; i++) dev_xfer(3'(i), 8'(8'h10 + i));
        chk("t4_count_full", {25'd0, rx_count}, 32'd8);
        chk("t4_overflow", {31'd0, rx_overflow}, 32'd1);
        chk("t4_head_first", {21'd0, rx_addr, rx_data}, {21'd0, 3'd0, 8'h10});
        ovf_clr = 1; tick(); ovf_clr = 0;
        chk("t4_ovf_cleared", {31'd0, rx_overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t4_pop_order", {21'd0, rx_addr, rx_data}, {21'd0, 3'(i), 8'(8'h10 + i)});
            rx_pop = 1; tick();
        end
        rx_pop = 0;
        chk("t4_empty", {25'd0, rx_count}, 32'd0);
        rx_pop = 1; tick(); rx_pop = 0;
        chk("t4_pop_empty_ignored", {25'd0, rx_count}, 32'd0);

        // 5: full FIFO, capture coincides with pop
        for (int i = 0; i < 8; i++) dev_xfer(3'(7 - i), 8'(8'h40 + i));
        chk("t5_full", {25'd0, rx_count}, 32'd8);
        uc_out = dev_word(3'd1, 8'h77); rx_pop = 1;
        tick(); rx_pop = 0;
        chk("t5_count_same", {25'd0, rx_count}, 32'd8);
        tick(); tick(); uc_out = 30'd0; tick();
        chk("t5_no_ovf", {31'd0, rx_overflow}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            exp_a[i] = 3'(6 - i); exp_d[i] = 8'(8'h41 + i);
        end
        exp_a[7] = 3'd1; exp_d[7] = 8'h77;
        for (int i = 0; i < 8; i++) begin
            chk("t5_pop_order", {21'd0, rx_addr, rx_data}, {21'd0, exp_a[i], exp_d[i]});
            rx_pop = 1; tick();
        end
        rx_pop = 0;
        chk("t5_empty", {25'd0, rx_count}, 32'd0);

        // 6: async reset during TX_CMD with an RX entry pending
        dev_xfer(3'd4, 8'h99);
        repeat (4) tick();
        chk("t6_rx_pending", {25'd0, rx_count}, 32'd1);
        tx_valid = 1; tx_addr = 3'd6; tx_data = 8'h5A;
        tick(); tx_valid = 0;
        tick();
        chk("t6_in_cmd", uc_in, 32'h3002_B400);
        #1 uc_reset = 1'b1;
        #1;
        chk("t6_rst_uc_in", uc_in, 32'd0);
        chk("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("t6_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("t6_rst_count", {25'd0, rx_count}, 32'd0);
        @(negedge uc_clk);
        uc_reset = 1'b0;
        tick();
        tx_valid = 1; tx_addr = 3'd1; tx_data = 8'hFF;
        tick(); tx_valid = 0;
        chk("t6_new_addr", uc_in, 32'h0800_0000);
        tick();
        chk("t6_new_cmd", uc_in, 32'h0803_FE00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
